// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for a loadable up/down counter: load lo, count to hi,
// count back to lo, repeated a programmed number of sweeps, with a start/busy/done handshake.
module updown_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [WIDTH-1:0]   ctr_count,
  output logic               ctr_load,
  output logic               ctr_mode,
  output logic [WIDTH-1:0]   ctr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [SWEEP_W-1:0] sw_q, sw_d;
  logic [SWEEP_W-1:0] sc_q, sc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      sw_q    <= '0;
      sc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sw_q    <= sw_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The counter has no enable, so the default drive is a reload of its own value.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    sw_d     = sw_q;
    sc_d     = sc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ctr_load = 1'b1;
    ctr_mode = 1'b0;
    ctr_data = ctr_count;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((hi > lo) && (sweeps != '0)) begin
            lo_d    = lo;
            hi_d    = hi;
            sw_d    = sweeps;
            sc_d    = '0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          ctr_data = lo_q;
          state_d  = S_UP;
        end
      end

      S_UP: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          ctr_load = 1'b0;
          if (ctr_count == hi_q) begin
            ctr_mode = 1'b0;
            state_d  = S_DOWN;
          end else begin
            ctr_mode = 1'b1;
          end
        end
      end

      S_DOWN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (ctr_count == lo_q) begin
          sc_d = sc_q + 1'b1;
          if (sc_d == sw_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            ctr_load = 1'b0;
            ctr_mode = 1'b1;
            state_d  = S_UP;
          end
        end else begin
          ctr_load = 1'b0;
          ctr_mode = 1'b0;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sc_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: drives a behavioural counter and checks each cycle
// against a triangle-profile model computed from lo/hi/sweeps.
module tb_updown_sweep_ctrl;
  localparam int W  = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [W-1:0]  lo, hi, ctr_count, ctr_data;
  logic [SW-1:0] sweeps, sweep_cnt;
  logic          ctr_load, ctr_mode, busy, done, err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  model_cnt;

  typedef struct packed {
    logic [W-1:0]  cnt;
    logic          busy;
    logic          done;
    logic [SW-1:0] sc;
  } exp_t;

  updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .sweeps(sweeps), .ctr_count(ctr_count),
    .ctr_load(ctr_load), .ctr_mode(ctr_mode), .ctr_data(ctr_data),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // The counter being sequenced
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ctr_count <= '0;
    else if (ctr_load) ctr_count <= ctr_data;
    else if (ctr_mode) ctr_count <= ctr_count + 1'b1;
    else               ctr_count <= ctr_count - 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected state after edge k of an accepted start (edge 1 accepts it).
  function automatic exp_t exp_at(input int k, input int l, input int h, input int s, input int c0);
    exp_t e;
    int d, p, last, j, m;
    d = h - l;
    p = 2 * d;
    last = 3 + p * s;
    e.busy = (k <= last);
    e.done = (k == last);
    if (k == 1) begin
      e.cnt = W'(c0);
      e.sc  = '0;
    end else if (k < last) begin
      j = k - 2;
      m = j % p;
      e.cnt = (m <= d) ? W'(l + m) : W'(l + p - m);
      e.sc  = (j > 0) ? SW'((j - 1) / p) : '0;
    end else begin
      e.cnt = W'(l);
      e.sc  = SW'(s);
    end
    return e;
  endfunction

  // ka: edge at which abort is sampled (0 = none); ki: edge for an intruding start while busy;
  // ds: request a fresh valid start during the DONE cycle.
  task automatic run_seq(input int l, input int h, input int s, input int ka, input int ki,
                         input bit ds, input string tag);
    int   last;
    exp_t e;
    last   = 3 + 2 * (h - l) * s;
    lo     = W'(l);
    hi     = W'(h);
    sweeps = SW'(s);
    start  = 1'b1;
    abort  = 1'b0;
    e      = '0;
    for (int k = 1; k <= last + 2; k++) begin
      tick;
      start = 1'b0;
      abort = 1'b0;
      e = exp_at(k, l, h, s, int'(model_cnt));
      if (ka != 0 && k >= ka) begin
        e = exp_at(ka - 1, l, h, s, int'(model_cnt));
        e.busy = 1'b0;
        e.done = 1'b0;
      end
      n_cmp++;
      if (ctr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL %s k=%0d count: got %0d want %0d", tag, k, ctr_count, e.cnt);
      end
      n_cmp++;
      if (busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s k=%0d busy: got %b want %b", tag, k, busy, e.busy);
      end
      n_cmp++;
      if (done !== e.done) begin
        n_bad++;
        $display("FAIL %s k=%0d done: got %b want %b", tag, k, done, e.done);
      end
      n_cmp++;
      if (sweep_cnt !== e.sc) begin
        n_bad++;
        $display("FAIL %s k=%0d sweep_cnt: got %0d want %0d", tag, k, sweep_cnt, e.sc);
      end
      n_cmp++;
      if (err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s k=%0d err: got %b want 0", tag, k, err);
      end
      if (k + 1 == ka) abort = 1'b1;
      if (k + 1 == ki) begin
        start = 1'b1; lo = 4'd1; hi = 4'd3; sweeps = 4'd1;
      end
      if (ds && k == last) begin
        start = 1'b1; lo = 4'd2; hi = 4'd6; sweeps = 4'd2;
      end
    end
    model_cnt = e.cnt;
    $display("seq %s lo=%0d hi=%0d sweeps=%0d abort@%0d final=%0d", tag, l, h, s, ka, model_cnt);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    lo = '0; hi = '0; sweeps = '0;
    #3;
    n_cmp++;
    if ({busy, done, err, sweep_cnt} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset outs: got %b want 0", {busy, done, err, sweep_cnt});
    end
    tick; tick;
    #2 reset = 1'b0;
    model_cnt = '0;
    tick; tick;
    n_cmp++;
    if (ctr_count !== model_cnt || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset idle hold: got cnt=%0d busy=%b want cnt=%0d busy=0", ctr_count, busy, model_cnt);
    end
    $display("reset done");
  endtask

  task automatic test_err(input int l, input int h, input int s, input string tag);
    lo = W'(l); hi = W'(h); sweeps = SW'(s); start = 1'b1;
    tick;
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s err pulse: got err=%b busy=%b want err=1 busy=0", tag, err, busy);
    end
    n_cmp++;
    if (ctr_count !== model_cnt) begin
      n_bad++;
      $display("FAIL %s hold: got %0d want %0d", tag, ctr_count, model_cnt);
    end
    tick;
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0 || ctr_count !== model_cnt) begin
      n_bad++;
      $display("FAIL %s after err: got err=%b busy=%b cnt=%0d want 0 0 %0d", tag, err, busy, ctr_count, model_cnt);
    end
    $display("err %s lo=%0d hi=%0d sweeps=%0d", tag, l, h, s);
  endtask

  task automatic test_async_reset;
    exp_t e;
    lo = 4'd3; hi = 4'd8; sweeps = 4'd2; start = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick;
      start = 1'b0;
      e = exp_at(k, 3, 8, 2, int'(model_cnt));
      n_cmp++;
      if (ctr_count !== e.cnt || busy !== e.busy || sweep_cnt !== e.sc) begin
        n_bad++;
        $display("FAIL arst k=%0d: got cnt=%0d busy=%b sc=%0d want %0d %b %0d",
                 k, ctr_count, busy, sweep_cnt, e.cnt, e.busy, e.sc);
      end
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, err, sweep_cnt} !== 7'b0 || ctr_count !== 4'd0) begin
      n_bad++;
      $display("FAIL arst clear: got busy=%b done=%b err=%b sc=%0d cnt=%0d want all 0",
               busy, done, err, sweep_cnt, ctr_count);
    end
    #2 reset = 1'b0;
    model_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL arst idle: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    $display("async reset mid-DOWN checked");
    run_seq(4, 6, 1, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    int l, h, s, last, r;
    for (int i = 0; i < 15; i++) begin
      l = $urandom_range(0, 13);
      h = $urandom_range(l + 1, 15);
      s = $urandom_range(1, 3);
      last = 3 + 2 * (h - l) * s;
      r = $urandom_range(0, 2);
      if (r == 1)      run_seq(l, h, s, $urandom_range(2, last), 0, 1'b0, "rand_abort");
      else if (r == 2) run_seq(l, h, s, 0, $urandom_range(2, last - 1), 1'b1, "rand_intr");
      else             run_seq(l, h, s, 0, 0, 1'b0, "rand");
      if ($urandom_range(0, 3) == 0) test_err(h, l, s, "rand_err");
    end
  endtask

  initial begin
    test_reset;
    run_seq(10, 12, 1, 0, 0, 1'b0, "basic");
    run_seq(2, 5, 3, 0, 0, 1'b0, "multi");
    test_err(7, 7, 1, "hi_eq_lo");
    test_err(3, 9, 0, "zero_sweeps");
    run_seq(0, 15, 2, 12, 0, 1'b0, "abort_up");
    run_seq(1, 6, 2, 0, 4, 1'b1, "start_busy");
    run_seq(1, 3, 1, 0, 0, 1'b0, "back_to_back");
    run_seq(5, 9, 1, 2, 0, 1'b0, "abort_load");
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
